// File: rtl/ma_cross_detect.sv
`default_nettype none
// ============================================================================
// Module      : ma_cross_detect
// Description : Golden/dead cross detector on two moving averages, with
//               warm-up discard, hysteresis and a saturating event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ma_cross_detect #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             e_in,
    input  logic [WIDTH-1:0] fast_avg,
    input  logic [WIDTH-1:0] slow_avg,
    input  logic [7:0]       warmup,
    input  logic [15:0]      hyst,
    output logic             buy,
    output logic             sell,
    output logic             trend,
    output logic             e_out,
    output logic [15:0]      cross_cnt
);

    // Sums are one bit wider than the widest operand so they can never wrap.
    localparam int SUM_W = ((WIDTH > 16) ? WIDTH : 16) + 1;

    localparam logic [1:0] c_WARM  = 2'd0;
    localparam logic [1:0] c_ABOVE = 2'd1;
    localparam logic [1:0] c_BELOW = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             buy_q, buy_d;
    logic             sell_q, sell_d;
    logic             trend_q, trend_d;
    logic             e_out_q, e_out_d;
    logic [15:0]      cross_cnt_q, cross_cnt_d;

    logic [SUM_W-1:0] w_fast_ext;
    logic [SUM_W-1:0] w_slow_ext;
    logic [SUM_W-1:0] w_hyst_ext;
    logic             w_rise;
    logic             w_fall;

    assign w_fast_ext = SUM_W'(fast_avg);
    assign w_slow_ext = SUM_W'(slow_avg);
    assign w_hyst_ext = SUM_W'(hyst);
    assign w_rise     = w_fast_ext > (w_slow_ext + w_hyst_ext);
    assign w_fall     = (w_fast_ext + w_hyst_ext) < w_slow_ext;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        buy_d       = 1'b0;
        sell_d      = 1'b0;
        e_out_d     = e_in;
        cross_cnt_d = cross_cnt_q;

        if (e_in) begin
            case (state_q)
                c_WARM: begin
                    if (wcnt_q < warmup) begin
                        wcnt_d = wcnt_q + 8'd1;
                    end else begin
                        state_d = (fast_avg >= slow_avg) ? c_ABOVE : c_BELOW;
                    end
                end
                c_BELOW: begin
                    if (w_rise) begin
                        state_d = c_ABOVE;
                        buy_d   = 1'b1;
                    end
                end
                c_ABOVE: begin
                    if (w_fall) begin
                        state_d = c_BELOW;
                        sell_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = c_WARM;
                    wcnt_d  = 8'd0;
                end
            endcase
        end

        if ((buy_d || sell_d) && (cross_cnt_q != 16'hFFFF)) begin
            cross_cnt_d = cross_cnt_q + 16'd1;
        end

        trend_d = (state_d == c_ABOVE);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= c_WARM;
            wcnt_q      <= 8'd0;
            buy_q       <= 1'b0;
            sell_q      <= 1'b0;
            trend_q     <= 1'b0;
            e_out_q     <= 1'b0;
            cross_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            buy_q       <= buy_d;
            sell_q      <= sell_d;
            trend_q     <= trend_d;
            e_out_q     <= e_out_d;
            cross_cnt_q <= cross_cnt_d;
        end
    end

    assign buy       = buy_q;
    assign sell      = sell_q;
    assign trend     = trend_q;
    assign e_out     = e_out_q;
    assign cross_cnt = cross_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ma_cross_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_ma_cross_detect
// Description : Self-checking bench for ma_cross_detect: directed scenarios
//               with literal expectations plus randomized traffic vs. a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ma_cross_detect;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             RST = 1'b0;
    logic             e_in = 1'b0;
    logic [WIDTH-1:0] fast_avg = '0;
    logic [WIDTH-1:0] slow_avg = '0;
    logic [7:0]       warmup = 8'd0;
    logic [15:0]      hyst = 16'd0;
    logic             buy, sell, trend, e_out;
    logic [15:0]      cross_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    ma_cross_detect #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .RST      (RST),
        .e_in     (e_in),
        .fast_avg (fast_avg),
        .slow_avg (slow_avg),
        .warmup   (warmup),
        .hyst     (hyst),
        .buy      (buy),
        .sell     (sell),
        .trend    (trend),
        .e_out    (e_out),
        .cross_cnt(cross_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = warming up, 1 = fast above slow, 2 = below.
    typedef struct packed {
        logic [1:0]  phase;
        logic [31:0] seen;
        logic [31:0] events;
        logic        b;
        logic        s;
        logic        ev;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t model_next(mdl_t cur, bit e, longint unsigned f,
                                        longint unsigned s, longint unsigned h,
                                        int unsigned wu);
        mdl_t n = cur;
        n.b  = 1'b0;
        n.s  = 1'b0;
        n.ev = e;
        if (e) begin
            if (cur.phase == 2'd0) begin
                if (cur.seen < wu) n.seen = cur.seen + 1;
                else               n.phase = (f >= s) ? 2'd1 : 2'd2;
            end else if (cur.phase == 2'd2 && f > s + h) begin
                n.phase = 2'd1;
                n.b     = 1'b1;
            end else if (cur.phase == 2'd1 && f + h < s) begin
                n.phase = 2'd2;
                n.s     = 1'b1;
            end
        end
        if ((n.b || n.s) && n.events < 65535) n.events = cur.events + 1;
        return n;
    endfunction

    always @(posedge clk or posedge RST) begin
        if (RST) m <= '0;
        else     m <= model_next(m, e_in, longint'(fast_avg), longint'(slow_avg),
                                 longint'(hyst), int'(warmup));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (buy !== m.b || sell !== m.s || trend !== (m.phase == 2'd1) ||
                e_out !== m.ev || cross_cnt !== m.events[15:0]) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t got b=%b s=%b t=%b e=%b c=%0d exp b=%b s=%b t=%b e=%b c=%0d",
                         $time, buy, sell, trend, e_out, cross_cnt,
                         m.b, m.s, (m.phase == 2'd1), m.ev, m.events[15:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Drive one cycle from a falling edge; returns at the next falling edge.
    task automatic cyc(input bit e, input logic [WIDTH-1:0] f, input logic [WIDTH-1:0] s);
        e_in     = e;
        fast_avg = f;
        slow_avg = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] wu);
        RST    = 1'b1;
        warmup = wu;
        e_in   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
    endtask

    initial begin
        #1 RST = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        do_reset(8'd2);
        chk("rst_buy", buy, 0);
        chk("rst_trend", trend, 0);
        chk("rst_cnt", cross_cnt, 0);

        // Warm-up then golden cross
        cyc(1, 5, 10);  chk("wu1_buy", buy, 0);
        cyc(1, 5, 10);  chk("wu2_buy", buy, 0);
        cyc(1, 5, 10);  chk("wu3_buy", buy, 0);  chk("wu3_trend", trend, 0);
        cyc(1, 11, 10); chk("gc_buy", buy, 1);   chk("gc_trend", trend, 1);
        chk("gc_cnt", cross_cnt, 1);
        cyc(0, 11, 10); chk("gc_pulse_end", buy, 0);

        // Hysteresis around slow=100
        hyst = 16'd3;
        cyc(1, 98, 100);  chk("hy98_sell", sell, 0);
        cyc(1, 96, 100);  chk("hy96_sell", sell, 1);
        cyc(1, 103, 100); chk("hy103_buy", buy, 0);
        cyc(1, 104, 100); chk("hy104_buy", buy, 1);
        chk("hy_cnt", cross_cnt, 3);

        // Wide threshold sums must not wrap
        hyst = 16'hFFFF;
        cyc(1, 0, 5);     chk("ovf_nosell", sell, 0); chk("ovf_trend1", trend, 1);
        hyst = 16'd0;
        cyc(1, 5, 10);    chk("ovf_prep_sell", sell, 1);
        hyst = 16'hFFFF;
        cyc(1, 32'hFFFFFFFF, 32'hFFFFFFF0); chk("ovf_nobuy", buy, 0);
        chk("ovf_trend0", trend, 0);

        // Gaps with crossing data are ignored
        hyst = 16'd0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 200, 10); chk("gap_nobuy", buy, 0);
        end
        cyc(1, 200, 10); chk("gap_buy", buy, 1); chk("gap_cnt", cross_cnt, 5);

        // Asynchronous reset mid-cycle, then warm-up restarts
        #2 RST = 1'b1;
        #1;
        chk("arst_outs", {buy, sell, trend, e_out}, 0);
        chk("arst_cnt", cross_cnt, 0);
        warmup = 8'd2;
        e_in = 1'b1; fast_avg = 20; slow_avg = 10;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        cyc(1, 20, 10); chk("rwu1_trend", trend, 0);
        cyc(1, 20, 10); chk("rwu2_trend", trend, 0);
        cyc(1, 20, 10); chk("rwu3_trend", trend, 1); chk("rwu3_buy", buy, 0);

        // Randomized traffic, checked by the model on every cycle
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] f, s;
            if ($urandom_range(199) == 0) do_reset(8'($urandom_range(5)));
            if ($urandom_range(49) == 0) hyst = 16'($urandom_range(19));
            if ($urandom_range(19) == 0) begin
                f = $urandom; s = $urandom;
            end else begin
                f = 1000 + $urandom_range(59);
                s = 1000 + $urandom_range(59);
            end
            cyc($urandom_range(3) != 0, f, s);
        end

        // Counter saturation
        do_reset(8'd0);
        hyst = 16'd0;
        cyc(1, 9, 10);
        for (int i = 0; i < 65535; i++) begin
            if (i % 2 == 0) cyc(1, 11, 10);
            else            cyc(1, 9, 10);
        end
        chk("sat_cnt", cross_cnt, 16'hFFFF);
        cyc(1, 9, 10);  chk("sat_sell", sell, 1); chk("sat_cnt_hold", cross_cnt, 16'hFFFF);
        cyc(1, 11, 10); chk("sat_buy", buy, 1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ma_cross_detect.md
MA_CROSS_DETECT -- requirements
Module: ma_cross_detect

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning average data width.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port e_in  in  1  sample valid; a cycle with e_in=1 is one accepted sample.
REQ-005 SHALL have port fast_avg  in  WIDTH  short-window moving average, unsigned.
REQ-006 SHALL have port slow_avg  in  WIDTH  long-window moving average, unsigned.
REQ-007 SHALL have port warmup  in  8  number of leading accepted samples discarded; held stable outside reset.
REQ-008 SHALL have port hyst  in  16  hysteresis margin, unsigned.
REQ-009 SHALL have port buy  out  1  one-cycle pulse on golden cross (fast rises above slow).
REQ-010 SHALL have port sell  out  1  one-cycle pulse on dead cross (fast falls below slow).
REQ-011 SHALL have port trend  out  1  1 = trend state ABOVE, 0 = otherwise.
REQ-012 SHALL have port e_out  out  1  e_in delayed one cycle.
REQ-013 SHALL have port cross_cnt  out  16  total buy+sell events, saturating.

Function
REQ-014 SHALL implement states WARM, ABOVE, BELOW plus an 8-bit warm-up counter wcnt.
REQ-015 In WARM, on an accepted sample with wcnt < warmup, SHALL increment wcnt and discard the sample.
REQ-016 In WARM, on an accepted sample with wcnt == warmup, SHALL go to ABOVE if fast_avg >= slow_avg, else to BELOW, with no pulse.
REQ-017 warmup=0 SHALL make the first accepted sample initialise the trend.
REQ-018 In BELOW, on an accepted sample with fast_avg > slow_avg + hyst, SHALL go to ABOVE and assert buy.
REQ-019 In ABOVE, on an accepted sample with fast_avg + hyst < slow_avg, SHALL go to BELOW and assert sell.
REQ-020 Threshold sums SHALL be computed at WIDTH+1 bits; no wrap-around is permitted.
REQ-021 Equality at the threshold (gap exactly hyst) SHALL NOT cause a transition.
REQ-022 buy, sell, trend and e_out SHALL be registered: latency one cycle from the sampling edge.
REQ-023 buy and sell SHALL each be high for exactly one cycle per event and never together.
REQ-024 Cycles with e_in=0 SHALL hold state, wcnt and cross_cnt, with buy=sell=0, whatever the data inputs.
REQ-025 Back-to-back accepted samples crossing alternately SHALL produce a pulse on every sample.
REQ-026 cross_cnt SHALL increment on each buy or sell and saturate at 16'hFFFF.
REQ-027 trend SHALL be 0 in WARM and BELOW.

Reset
REQ-028 RST=1 SHALL asynchronously force state=WARM, wcnt=0, and buy, sell, trend, e_out, cross_cnt all 0.
REQ-029 RST asserted mid-operation SHALL discard the trend; after release the warm-up restarts from wcnt=0.
REQ-030 Accepted samples SHALL NOT be counted while RST=1.

Verification
REQ-031 Reset: RST=1 while in ABOVE with cross_cnt=5 -> all outputs 0 immediately (no clock needed); after release, warmup samples are discarded again.
REQ-032 Warm-up/golden cross: warmup=2, hyst=0, samples (fast,slow) = (5,10),(5,10),(5,10),(11,10) -> no pulse on the first three, trend=0 after the third, buy=1 for one cycle after the fourth, trend=1, cross_cnt=1.
REQ-033 Hysteresis: hyst=3, state ABOVE, slow=100, fast sequence 98,96,103,104 -> sell only after 96, buy only after 104, cross_cnt +2.
REQ-034 Gaps: in BELOW, e_in=0 for 4 cycles with fast=200, slow=10 -> no buy; the next accepted sample with the same data -> buy.
REQ-035 Overflow: in BELOW, fast=32'hFFFFFFFF, slow=32'hFFFFFFF0, hyst=16'hFFFF -> no buy; in ABOVE, fast=0, slow=5, hyst=16'hFFFF -> no sell.
REQ-036 Saturation: with cross_cnt preloaded by 65535 alternating crosses, a further cross -> pulse still issued, cross_cnt stays 16'hFFFF.
